// File: rtl/program_counter_stack_if.sv
// Sequencing bus between the control unit (master) and the program counter
// with return-address stack (slave). clk/rst stay outside as plain ports.
interface program_counter_stack_if #(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   logic             pc_enable;
   logic             jump;
   logic             branch;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] target_addr;
   logic [WIDTH-1:0] branch_offset;
   logic [WIDTH-1:0] count;
   logic [SPW-1:0]   sp;
   logic             stack_full;
   logic             stack_empty;
   logic             ovf_err;
   logic             unf_err;

   // Strobes are level-qualified by pc_enable; one operation is taken per enabled edge.
   modport master (
      output pc_enable, jump, branch, call, ret, target_addr, branch_offset,
      input  count, sp, stack_full, stack_empty, ovf_err, unf_err
   );

   modport slave (
      input  pc_enable, jump, branch, call, ret, target_addr, branch_offset,
      output count, sp, stack_full, stack_empty, ovf_err, unf_err
   );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with jump, signed branch and call/return through a
// return-address stack. Priority when enabled: ret > call > jump > branch > increment.
module program_counter_stack #(
   parameter int               WIDTH        = 8,
   parameter int               STACK_DEPTH  = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   program_counter_stack_if.slave   pc_if
);
   localparam int AW  = $clog2(STACK_DEPTH);
   localparam int SPW = AW + 1;

   logic [WIDTH-1:0] count_q, count_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] stack_q [STACK_DEPTH];

   logic [WIDTH-1:0] count_inc;
   logic [SPW-1:0]   sp_dec;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    pop_idx;
   logic             push_en;
   logic             full;
   logic             empty;

   assign count_inc = count_q + WIDTH'(1);
   assign sp_dec    = sp_q - SPW'(1);
   assign push_idx  = sp_q[AW-1:0];
   assign pop_idx   = sp_dec[AW-1:0];
   assign full      = (sp_q == SPW'(STACK_DEPTH));
   assign empty     = (sp_q == '0);

   always_comb begin
      count_d = count_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (pc_if.pc_enable) begin
         if (pc_if.ret) begin
            if (!empty) begin
               count_d = stack_q[pop_idx];
               sp_d    = sp_dec;
            end else begin
               count_d = count_inc;
               unf_d   = 1'b1;
            end
         end else if (pc_if.call) begin
            // A call on a full stack degrades to a plain increment.
            if (!full) begin
               push_en = 1'b1;
               count_d = pc_if.target_addr;
               sp_d    = sp_q + SPW'(1);
            end else begin
               count_d = count_inc;
               ovf_d   = 1'b1;
            end
         end else if (pc_if.jump) begin
            count_d = pc_if.target_addr;
         end else if (pc_if.branch) begin
            count_d = count_q + pc_if.branch_offset;
         end else begin
            count_d = count_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= RESET_VECTOR;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents are not reset; a push during reset is abandoned.
   always_ff @(posedge clk) begin
      if (push_en && rst) begin
         stack_q[push_idx] <= count_inc;
      end
   end

   assign pc_if.count       = count_q;
   assign pc_if.sp          = sp_q;
   assign pc_if.stack_full  = full;
   assign pc_if.stack_empty = empty;
   assign pc_if.ovf_err     = ovf_q;
   assign pc_if.unf_err     = unf_q;
endmodule
